// File: rtl/hazard_stall_if.sv
// Pipeline-status / stall-control bundle shared between the pipeline and the hazard unit.
// master = pipeline side (drives stage status), slave = hazard_stall_unit.
interface hazard_stall_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             pc_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_err;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_en,
               if_id_flush, id_ex_flush, stall_cycles, mem_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        output if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_en,
               if_id_flush, id_ex_flush, stall_cycles, mem_err
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller: load-use bubbles, memory-wait freezes and branch squashes,
// with a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_stall_unit #(
    parameter int REG_W       = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_stall_if.slave  bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic {
        S_RUN,
        S_MEM_WAIT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              r_mem_err;

    logic              w_hz;
    logic              w_mem_stall;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_if_id_en;
    logic              w_id_ex_en;
    logic              w_ex_mem_en;
    logic              w_mem_wb_en;
    logic              w_if_id_flush;
    logic              w_id_ex_flush;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign w_hz = bus.ex_mem_read && (bus.ex_rd != '0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // A dropped mem_req releases the wait exactly like mem_ready does.
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    assign w_wait_next = (r_state == S_RUN)     ? WAIT_ONE :
                         (r_wait_cnt >= WAIT_MAX) ? WAIT_MAX : r_wait_cnt + WAIT_ONE;

    always_comb begin
        w_if_id_en    = 1'b0;
        w_id_ex_en    = 1'b0;
        w_ex_mem_en   = 1'b0;
        w_mem_wb_en   = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (rst) begin
            if (r_state == S_MEM_WAIT) begin
                if (!w_mem_stall) begin
                    {w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 4'b1111;
                end
            end else if (w_mem_stall) begin
                {w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 4'b0000;
            end else if (bus.branch_taken) begin
                {w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 4'b1111;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_hz) begin
                // Hold IF/ID and PC for one cycle while a NOP enters EX behind the load.
                {w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 4'b0111;
                w_id_ex_flush = 1'b1;
            end else begin
                {w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RUN;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
            r_mem_err      <= 1'b0;
        end else begin
            if (w_mem_stall) begin
                r_state    <= S_MEM_WAIT;
                r_wait_cnt <= w_wait_next;
                if (w_wait_next >= WAIT_MAX) begin
                    r_mem_err <= 1'b1;
                end
            end else begin
                r_state    <= S_RUN;
                r_wait_cnt <= '0;
            end
            if (!w_if_id_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign bus.if_id_en     = w_if_id_en;
    assign bus.pc_en        = w_if_id_en;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.mem_wb_en    = w_mem_wb_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.mem_err      = r_mem_err;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios plus random traffic,
// checked against a cycle-level model of the stall rules; a CNT_W=4 copy covers saturation.
module tb_hazard_stall_unit;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_if #(.REG_W(3), .CNT_W(16)) aif ();
    hazard_stall_if #(.REG_W(3), .CNT_W(4))  bif ();

    assign bif.id_rs1       = aif.id_rs1;
    assign bif.id_rs2       = aif.id_rs2;
    assign bif.id_uses_rs1  = aif.id_uses_rs1;
    assign bif.id_uses_rs2  = aif.id_uses_rs2;
    assign bif.ex_mem_read  = aif.ex_mem_read;
    assign bif.ex_rd        = aif.ex_rd;
    assign bif.branch_taken = aif.branch_taken;
    assign bif.mem_req      = aif.mem_req;
    assign bif.mem_ready    = aif.mem_ready;

    hazard_stall_unit #(.REG_W(3), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (aif.slave)
    );

    hazard_stall_unit #(.REG_W(3), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // ctl = {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_en, if_id_flush, id_ex_flush}
    localparam logic [6:0] C_ALL0 = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1111100;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_BUB  = 7'b0111001;

    typedef struct {
        logic [6:0] ctl;
        int         sa;
        int         sb;
        bit         err;
    } exp_t;

    exp_t q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    bit  stim_done = 1'b0;

    // Model state: consecutive stalled-memory cycles, stall counters, sticky error.
    int  m_wait = 0;
    int  m_sa   = 0;
    int  m_sb   = 0;
    bit  m_err  = 1'b0;

    task automatic step(input bit rst_v, input logic [2:0] rs1, input logic [2:0] rs2,
                        input bit u1, input bit u2, input bit ld, input logic [2:0] rd,
                        input bit br, input bit req, input bit rdy);
        exp_t       e;
        bit         hz;
        bit         ms;
        logic [6:0] c;
        @(posedge clk);
        #1;
        rst              = rst_v;
        aif.id_rs1       = rs1;
        aif.id_rs2       = rs2;
        aif.id_uses_rs1  = u1;
        aif.id_uses_rs2  = u2;
        aif.ex_mem_read  = ld;
        aif.ex_rd        = rd;
        aif.branch_taken = br;
        aif.mem_req      = req;
        aif.mem_ready    = rdy;
        if (!rst_v) begin
            m_wait = 0;
            m_sa   = 0;
            m_sb   = 0;
            m_err  = 1'b0;
            e = '{ctl: C_ALL0, sa: 0, sb: 0, err: 1'b0};
            q.push_back(e);
        end else begin
            hz = ld && (rd != 3'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            ms = req && !rdy;
            if (m_wait > 0)  c = ms ? C_ALL0 : C_RUN;
            else if (ms)     c = C_ALL0;
            else if (br)     c = C_BR;
            else if (hz)     c = C_BUB;
            else             c = C_RUN;
            e = '{ctl: c, sa: m_sa, sb: m_sb, err: m_err};
            q.push_back(e);
            m_wait = ms ? m_wait + 1 : 0;
            if (ms && m_wait >= TMO) m_err = 1'b1;
            if (!c[6]) begin
                m_sa = (m_sa < 65535) ? m_sa + 1 : 65535;
                m_sb = (m_sb < 15) ? m_sb + 1 : 15;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_step(input bit rst_v);
        step(rst_v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 99) < 55));
    endtask

    // Monitor: every cycle presents a full control word; compare it against the queue head.
    initial begin
        exp_t       e;
        logic [6:0] a_ctl;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                cyc++;
                a_ctl = {aif.if_id_en, aif.id_ex_en, aif.ex_mem_en, aif.mem_wb_en,
                         aif.pc_en, aif.if_id_flush, aif.id_ex_flush};
                $display("txn %0d: rst=%b ctl=%b stall=%0d/%0d err=%b", cyc, rst, a_ctl,
                         aif.stall_cycles, bif.stall_cycles, aif.mem_err);
                n_checks++;
                if (a_ctl !== e.ctl || bif.if_id_en !== e.ctl[6]) begin
                    n_errors++;
                    $display("FAIL ctl cyc %0d: got %b, expected %b", cyc, a_ctl, e.ctl);
                end
                n_checks++;
                if (aif.stall_cycles !== 16'(e.sa)) begin
                    n_errors++;
                    $display("FAIL stall16 cyc %0d: got %0d, expected %0d", cyc, aif.stall_cycles, e.sa);
                end
                n_checks++;
                if (bif.stall_cycles !== 4'(e.sb)) begin
                    n_errors++;
                    $display("FAIL stall4 cyc %0d: got %0d, expected %0d", cyc, bif.stall_cycles, e.sb);
                end
                n_checks++;
                if (aif.mem_err !== e.err || bif.mem_err !== e.err) begin
                    n_errors++;
                    $display("FAIL mem_err cyc %0d: got %b/%b, expected %b", cyc, aif.mem_err, bif.mem_err, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aif.id_rs1 = 0; aif.id_rs2 = 0; aif.id_uses_rs1 = 0; aif.id_uses_rs2 = 0;
        aif.ex_mem_read = 0; aif.ex_rd = 0; aif.branch_taken = 0;
        aif.mem_req = 0; aif.mem_ready = 0;

        for (int i = 0; i < 3; i++) rnd_step(0);
        idle(2);

        // load-use on rs2, then the same with ex_rd = 0
        step(1, 1, 3, 0, 1, 1, 3, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 5, 2, 1, 0, 1, 5, 0, 0, 0);
        // single-cycle memory access: no stall
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // 4-cycle memory wait, then ready
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // timeout: 20 wait cycles, then ready
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // priority: branch over load-use, memory wait over branch
        step(1, 4, 0, 1, 0, 1, 4, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 4, 0, 1, 0, 1, 4, 1, 1, 0);
        step(1, 4, 0, 1, 0, 1, 4, 1, 0, 0);   // mem_req dropped: release, branch ignored
        step(1, 4, 0, 1, 0, 1, 4, 1, 0, 0);

        // reset during a memory wait
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        for (int i = 0; i < 400; i++) rnd_step($urandom_range(0, 99) != 0);
        idle(2);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
